// File: rtl/serial_pkg.sv
// Shared definitions for the serial transmit arbiter: FSM state encoding,
// requester index width helper and the UART bit-rate prescale constant.
package serial_pkg;

  // Arbiter FSM states: waiting for a requester, or locked to one frame owner
  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_LOCK = 1'b1
  } state_t;

  // System clock and baud rate that the shared uart_tx is configured for
  localparam int CLOCK_HZ      = 50_000_000;
  localparam int BAUD_RATE     = 9600;
  // uart_tx oversamples each bit 8 times
  localparam int UART_PRESCALE = CLOCK_HZ / (BAUD_RATE * 8);

  // Width of a requester index; never narrower than one bit
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/serial_rr_pick.sv
// Rotating-priority picker: starting at ptr and wrapping around, selects the
// first requester whose valid bit is set. Purely combinational.
module serial_rr_pick
  import serial_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = idx_width(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] valid,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   idx,
  output logic               any
);

  logic [IDX_W:0]   sum;
  logic [IDX_W-1:0] pos;

  // Scan ptr, ptr+1, ... modulo NUM_REQ and keep the first valid hit
  always_comb begin
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    sum   = '0;
    pos   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      sum = {1'b0, ptr} + (IDX_W + 1)'(i);
      if (sum >= (IDX_W + 1)'(NUM_REQ)) begin
        sum = sum - (IDX_W + 1)'(NUM_REQ);
      end
      pos = sum[IDX_W-1:0];
      if (!any && valid[pos]) begin
        any        = 1'b1;
        idx        = pos;
        grant[pos] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/serial_tx_arbiter.sv
// Frame-based round-robin arbiter that shares one uart_tx stream input among
// several byte producers. A grant is held for a whole frame (up to the byte
// flagged last) or until the owner stalls for too long without offering data.
module serial_tx_arbiter
  import serial_pkg::*;
#(
  parameter int NUM_REQ          = 4,
  parameter int SERIAL_DATA_SIZE = 8,
  parameter int TIMEOUT_CYCLES   = 1024,
  parameter int TIMEOUT_SIZE     = 16
) (
  input  logic                                i_clock,
  input  logic                                i_reset,
  input  logic [NUM_REQ*SERIAL_DATA_SIZE-1:0] i_req_data,
  input  logic [NUM_REQ-1:0]                  i_req_valid,
  input  logic [NUM_REQ-1:0]                  i_req_last,
  output logic [NUM_REQ-1:0]                  o_req_ready,
  output logic [SERIAL_DATA_SIZE-1:0]         o_tx_data,
  output logic                                o_tx_valid,
  input  logic                                i_tx_ready,
  output logic [NUM_REQ-1:0]                  o_grant,
  output logic                                o_busy,
  output logic                                o_timeout
);

  localparam int W     = SERIAL_DATA_SIZE;
  localparam int IDX_W = idx_width(NUM_REQ);
  localparam logic [IDX_W-1:0]        LAST_IDX     = IDX_W'(NUM_REQ - 1);
  localparam logic [TIMEOUT_SIZE-1:0] TIMEOUT_LAST = TIMEOUT_SIZE'(TIMEOUT_CYCLES - 1);

  state_t                  state;
  state_t                  state_next;
  logic [IDX_W-1:0]        rr_ptr;
  logic [IDX_W-1:0]        owner;
  logic [NUM_REQ-1:0]      owner_onehot;
  logic [TIMEOUT_SIZE-1:0] idle_cnt;

  logic [NUM_REQ-1:0]      pick_grant;
  logic [IDX_W-1:0]        pick_idx;
  logic                    pick_any;

  logic [W-1:0]            owner_data;
  logic                    owner_valid;
  logic                    owner_last;
  logic                    owner_ready;
  logic                    accept;
  logic                    timeout_hit;
  logic [IDX_W-1:0]        next_ptr;

  serial_rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_pick (
    .valid (i_req_valid),
    .ptr   (rr_ptr),
    .grant (pick_grant),
    .idx   (pick_idx),
    .any   (pick_any)
  );

  // Route the current owner's byte, valid and last onto shared wires
  always_comb begin
    owner_data  = '0;
    owner_valid = 1'b0;
    owner_last  = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (owner == IDX_W'(k)) begin
        owner_data  = i_req_data[k*W +: W];
        owner_valid = i_req_valid[k];
        owner_last  = i_req_last[k];
      end
    end
  end

  // Handshake, stall timeout and round-robin successor of the owner
  always_comb begin
    owner_ready = !o_tx_valid || i_tx_ready;
    accept      = (state == ST_LOCK) && owner_valid && owner_ready;
    timeout_hit = (TIMEOUT_CYCLES != 0) && (state == ST_LOCK) &&
                  !owner_valid && (idle_cnt == TIMEOUT_LAST);
    next_ptr    = (owner == LAST_IDX) ? '0 : owner + 1'b1;
  end

  // FSM state register
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // FSM next state: lock onto a picked requester, release on last byte or stall
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: if (pick_any) state_next = ST_LOCK;
      ST_LOCK: if ((accept && owner_last) || timeout_hit) state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  // FSM outputs: grant and ready only while locked, busy also covers a pending byte
  always_comb begin
    o_grant     = '0;
    o_req_ready = '0;
    o_busy      = o_tx_valid;
    if (state == ST_LOCK) begin
      o_grant = owner_onehot;
      o_busy  = 1'b1;
      if (owner_ready) begin
        o_req_ready = owner_onehot;
      end
    end
  end

  // Capture the chosen owner and advance the rotation pointer when a grant ends
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      owner        <= '0;
      owner_onehot <= '0;
      rr_ptr       <= '0;
    end else begin
      if (state == ST_IDLE && pick_any) begin
        owner        <= pick_idx;
        owner_onehot <= pick_grant;
      end
      if (state == ST_LOCK && state_next == ST_IDLE) begin
        rr_ptr <= next_ptr;
      end
    end
  end

  // Count owner-idle cycles; backpressure holds the count, an accept clears it
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      idle_cnt <= '0;
    end else if (state != ST_LOCK || accept || state_next == ST_IDLE) begin
      idle_cnt <= '0;
    end else if (!owner_valid) begin
      idle_cnt <= idle_cnt + 1'b1;
    end
  end

  // Single-entry output register toward uart_tx; drain and refill may coincide
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      o_tx_valid <= 1'b0;
      o_tx_data  <= '0;
    end else if (accept) begin
      o_tx_valid <= 1'b1;
      o_tx_data  <= owner_data;
    end else if (i_tx_ready) begin
      o_tx_valid <= 1'b0;
    end
  end

  // One-cycle pulse marking a grant revoked by the stall timeout
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      o_timeout <= 1'b0;
    end else begin
      o_timeout <= timeout_hit;
    end
  end

endmodule
